// File: rtl/m_control_pkg.sv
// Shared definitions for the M-extension sequencing controller:
// op encodings, ALU mux encodings, FSM state type and mux-select helpers.
package m_control_pkg;

  localparam int XLEN_DEFAULT      = 32;
  localparam int DIV_ITERS_DEFAULT = 32;

  // funct3 encodings of the RV32M operations
  localparam int         M_OP_W      = 3;
  localparam logic [2:0] M_OP_MUL    = 3'd0;
  localparam logic [2:0] M_OP_MULH   = 3'd1;
  localparam logic [2:0] M_OP_MULHSU = 3'd2;
  localparam logic [2:0] M_OP_MULHU  = 3'd3;
  localparam logic [2:0] M_OP_DIV    = 3'd4;
  localparam logic [2:0] M_OP_DIVU   = 3'd5;
  localparam logic [2:0] M_OP_REM    = 3'd6;
  localparam logic [2:0] M_OP_REMU   = 3'd7;

  // ALU mux encodings
  localparam int MUX_MULTA_LENGTH   = 2;
  localparam int MUX_MULTB_LENGTH   = 2;
  localparam int MUX_DIV_REM_LENGTH = 1;

  localparam logic [MUX_MULTA_LENGTH-1:0]   MUX_MULTA_ZERO     = 2'd0;
  localparam logic [MUX_MULTA_LENGTH-1:0]   MUX_MULTA_UNSIGNED = 2'd1;
  localparam logic [MUX_MULTA_LENGTH-1:0]   MUX_MULTA_SIGNED   = 2'd2;
  localparam logic [MUX_MULTB_LENGTH-1:0]   MUX_MULTB_ZERO     = 2'd0;
  localparam logic [MUX_MULTB_LENGTH-1:0]   MUX_MULTB_UNSIGNED = 2'd1;
  localparam logic [MUX_MULTB_LENGTH-1:0]   MUX_MULTB_SIGNED   = 2'd2;
  localparam logic [MUX_DIV_REM_LENGTH-1:0] MUX_DIV_REM_R      = 1'b0;
  localparam logic [MUX_DIV_REM_LENGTH-1:0] MUX_DIV_REM_Z      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_ITER,
    ST_DIV_FIX,
    ST_DONE
  } m_ctrl_state_t;

  // Multiplier A (rs1) is signed for MULH and MULHSU
  function automatic logic [MUX_MULTA_LENGTH-1:0] mul_sel_a(input logic [M_OP_W-1:0] op);
    return (op == M_OP_MULH || op == M_OP_MULHSU) ? MUX_MULTA_SIGNED : MUX_MULTA_UNSIGNED;
  endfunction

  // Multiplier B (rs2) is signed only for MULH
  function automatic logic [MUX_MULTB_LENGTH-1:0] mul_sel_b(input logic [M_OP_W-1:0] op);
    return (op == M_OP_MULH) ? MUX_MULTB_SIGNED : MUX_MULTB_UNSIGNED;
  endfunction

endpackage

// File: rtl/m_control_if.sv
// Request/response handshake between the execute stage and the M controller.
interface m_control_if
  import m_control_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic              valid_i;
  logic              ready_o;
  logic [M_OP_W-1:0] op_i;
  logic [XLEN-1:0]   rs1_i;
  logic [XLEN-1:0]   rs2_i;
  logic              abort_i;
  logic [XLEN-1:0]   result_o;
  logic              result_valid_o;
  logic              result_ready_i;

  // Execute-stage side
  modport master (
    output valid_i, op_i, rs1_i, rs2_i, abort_i, result_ready_i,
    input  ready_o, result_o, result_valid_o
  );

  // Controller side
  modport slave (
    input  valid_i, op_i, rs1_i, rs2_i, abort_i, result_ready_i,
    output ready_o, result_o, result_valid_o
  );

endinterface

// File: rtl/m_control_operand_prep.sv
// Combinational operand classification and sign/magnitude preparation
// for the division path, including the early-resolved corner cases.
module m_control_operand_prep
  import m_control_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [M_OP_W-1:0] i_op,
  input  logic [XLEN-1:0]   i_rs1,
  input  logic [XLEN-1:0]   i_rs2,
  output logic              o_is_div,
  output logic              o_is_rem,
  output logic              o_div_zero,
  output logic              o_overflow,
  output logic              o_neg_q,
  output logic              o_neg_r,
  output logic [XLEN-1:0]   o_rs1_mag,
  output logic [XLEN-1:0]   o_rs2_mag
);

  logic w_signed;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // DIV/REM are the signed division ops (funct3 bit 0 clear)
  assign o_is_div = i_op[2];
  assign o_is_rem = i_op[2] & i_op[1];
  assign w_signed = i_op[2] & ~i_op[0];

  // Two's complement negation of the most negative value yields itself,
  // which read as unsigned is exactly the required magnitude.
  assign o_rs1_mag = (w_signed && i_rs1[XLEN-1]) ? (~i_rs1 + 1'b1) : i_rs1;
  assign o_rs2_mag = (w_signed && i_rs2[XLEN-1]) ? (~i_rs2 + 1'b1) : i_rs2;

  assign o_div_zero = (i_rs2 == '0);
  assign o_overflow = w_signed && (i_rs1 == MOST_NEG) && (i_rs2 == '1);
  assign o_neg_q    = w_signed && (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
  assign o_neg_r    = w_signed && i_rs1[XLEN-1];

endmodule

// File: rtl/m_control.sv
// Sequencing controller for the M-extension ALU: accepts one RV32M op,
// drives the multiplier selects or runs a restoring division, and returns
// the result over a valid/ready handshake.
module m_control
  import m_control_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
  input  logic                          clk,
  input  logic                          resetn,
  m_control_if.slave                    bus,
  output logic [MUX_MULTA_LENGTH-1:0]   mux_multA_o,
  output logic [MUX_MULTB_LENGTH-1:0]   mux_multB_o,
  output logic [MUX_DIV_REM_LENGTH-1:0] mux_div_rem_o,
  output logic [XLEN-1:0]               R_o,
  output logic [2*XLEN-2:0]             D_o,
  output logic [XLEN-1:0]               Z_o,
  input  logic [XLEN-1:0]               sub_result_i,
  input  logic [XLEN-1:0]               div_rem_i,
  input  logic [XLEN-1:0]               div_rem_neg_i,
  input  logic [2*XLEN-1:0]             product_i
);

  localparam int CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  m_ctrl_state_t                 r_state;
  logic [XLEN-1:0]               r_R;
  logic [2*XLEN-2:0]             r_D;
  logic [XLEN-1:0]               r_Z;
  logic [XLEN-1:0]               r_result;
  logic                          r_result_valid;
  logic [MUX_MULTA_LENGTH-1:0]   r_mux_a;
  logic [MUX_MULTB_LENGTH-1:0]   r_mux_b;
  logic [MUX_DIV_REM_LENGTH-1:0] r_mux_dr;
  logic [M_OP_W-1:0]             r_op;
  logic [CNT_W-1:0]              r_cnt;
  logic                          r_neg_q;
  logic                          r_neg_r;

  logic            w_is_div, w_is_rem, w_div_zero, w_overflow, w_neg_q, w_neg_r;
  logic [XLEN-1:0] w_rs1_mag, w_rs2_mag;
  logic            w_fits;

  m_control_operand_prep #(.XLEN(XLEN)) u_prep (
    .i_op       (bus.op_i),
    .i_rs1      (bus.rs1_i),
    .i_rs2      (bus.rs2_i),
    .o_is_div   (w_is_div),
    .o_is_rem   (w_is_rem),
    .o_div_zero (w_div_zero),
    .o_overflow (w_overflow),
    .o_neg_q    (w_neg_q),
    .o_neg_r    (w_neg_r),
    .o_rs1_mag  (w_rs1_mag),
    .o_rs2_mag  (w_rs2_mag)
  );

  // The divisor only fits once its upper bits have shifted out of range of R
  assign w_fits = (r_D[2*XLEN-2:XLEN] == '0) && (r_R >= r_D[XLEN-1:0]);

  assign bus.ready_o        = resetn && (r_state == ST_IDLE);
  assign bus.result_o       = r_result;
  assign bus.result_valid_o = r_result_valid;
  assign mux_multA_o        = r_mux_a;
  assign mux_multB_o        = r_mux_b;
  assign mux_div_rem_o      = r_mux_dr;
  assign R_o                = r_R;
  assign D_o                = r_D;
  assign Z_o                = r_Z;

  // Controller FSM with registered outputs; abort overrides any state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_R            <= '0;
      r_D            <= '0;
      r_Z            <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_mux_a        <= MUX_MULTA_ZERO;
      r_mux_b        <= MUX_MULTB_ZERO;
      r_mux_dr       <= MUX_DIV_REM_R;
      r_op           <= '0;
      r_cnt          <= '0;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
    end else if (bus.abort_i) begin
      r_state        <= ST_IDLE;
      r_result_valid <= 1'b0;
      r_mux_a        <= MUX_MULTA_ZERO;
      r_mux_b        <= MUX_MULTB_ZERO;
      r_mux_dr       <= MUX_DIV_REM_R;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.valid_i) begin
            r_op <= bus.op_i;
            if (!w_is_div) begin
              r_R     <= bus.rs1_i;
              r_D     <= {bus.rs2_i, {(XLEN-1){1'b0}}};
              r_mux_a <= mul_sel_a(bus.op_i);
              r_mux_b <= mul_sel_b(bus.op_i);
              r_state <= ST_MUL;
            end else if (w_div_zero) begin
              r_result       <= w_is_rem ? bus.rs1_i : '1;
              r_result_valid <= 1'b1;
              r_state        <= ST_DONE;
            end else if (w_overflow) begin
              r_result       <= w_is_rem ? '0 : MOST_NEG;
              r_result_valid <= 1'b1;
              r_state        <= ST_DONE;
            end else begin
              r_R      <= w_rs1_mag;
              r_D      <= {w_rs2_mag, {(XLEN-1){1'b0}}};
              r_Z      <= '0;
              r_cnt    <= CNT_W'(DIV_ITERS - 1);
              r_neg_q  <= w_neg_q;
              r_neg_r  <= w_neg_r;
              r_mux_dr <= w_is_rem ? MUX_DIV_REM_R : MUX_DIV_REM_Z;
              r_state  <= ST_DIV_ITER;
            end
          end
        end
        ST_MUL: begin
          r_result       <= (r_op == M_OP_MUL) ? product_i[XLEN-1:0] : product_i[2*XLEN-1:XLEN];
          r_result_valid <= 1'b1;
          r_mux_a        <= MUX_MULTA_ZERO;
          r_mux_b        <= MUX_MULTB_ZERO;
          r_state        <= ST_DONE;
        end
        ST_DIV_ITER: begin
          if (w_fits) begin
            r_R <= sub_result_i;
          end
          r_Z <= {r_Z[XLEN-2:0], w_fits};
          r_D <= r_D >> 1;
          if (r_cnt == '0) begin
            r_state <= ST_DIV_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DIV_FIX: begin
          r_result       <= (r_op[1] ? r_neg_r : r_neg_q) ? div_rem_neg_i : div_rem_i;
          r_result_valid <= 1'b1;
          r_state        <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.result_ready_i) begin
            r_result_valid <= 1'b0;
            r_mux_dr       <= MUX_DIV_REM_R;
            r_state        <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
